// File: rtl/display_pkg.sv
// Shared definitions for the display source selector.
// Contents: default pixel width, zero colour, FSM state encoding,
// blank counter width and the select-width helper.
package display_pkg;

  localparam int unsigned RGB_W       = 12;
  localparam int unsigned STATE_W     = 2;
  localparam int unsigned BLANK_CNT_W = 4;

  localparam logic [RGB_W-1:0] RGB_ZERO = '0;

  // Selector FSM states
  localparam logic [STATE_W-1:0] ST_SHOW  = 2'd0;
  localparam logic [STATE_W-1:0] ST_PEND  = 2'd1;
  localparam logic [STATE_W-1:0] ST_BLANK = 2'd2;

  // Index width for n sources; never below one bit so a 2-source build still has a select line
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/src_prio_enc.sv
// Lowest-index priority encoder over the per-source active flags.
// Ports:
//   req   : one flag per source
//   idx   : index of the lowest set flag (0 when none)
//   valid : at least one flag set
module src_prio_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan from the top down so the lowest set index wins
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_source_mux.sv
// Video-source selector feeding the VGA output. Chooses one of NUM_SRC
// RGB streams (manual or auto from active flags) and commits a change only
// at a frame boundary, optionally inserting whole black frames.
// Ports:
//   vga_clk, rst : pixel clock, asynchronous active-high reset
//   src_rgb      : packed sources, source i at [i*RGB_W +: RGB_W]
//   src_active   : per-source running flags (auto mode)
//   auto_en      : 1 = auto select, 0 = manual_sel
//   manual_sel   : requested source in manual mode
//   hsync_de     : horizontal display enable
//   vsync_de     : vertical display enable
//   rgb_out      : selected pixel, PIPE cycles after its inputs
//   cur_sel      : committed source
//   switching    : switch pending or blanking in progress
module display_source_mux
  import display_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned RGB_W        = display_pkg::RGB_W,
  parameter int unsigned DEFAULT_SRC  = 0,
  parameter int unsigned BLANK_FRAMES = 1,
  parameter int unsigned PIPE         = 1,
  localparam int unsigned SEL_W       = sel_width(NUM_SRC)
) (
  input  logic                       vga_clk,
  input  logic                       rst,
  input  logic [NUM_SRC*RGB_W-1:0]   src_rgb,
  input  logic [NUM_SRC-1:0]         src_active,
  input  logic                       auto_en,
  input  logic [SEL_W-1:0]           manual_sel,
  input  logic                       hsync_de,
  input  logic                       vsync_de,
  output logic [RGB_W-1:0]           rgb_out,
  output logic [SEL_W-1:0]           cur_sel,
  output logic                       switching
);

  localparam logic [SEL_W-1:0]       DEF_SEL    = SEL_W'(DEFAULT_SRC);
  localparam logic [BLANK_CNT_W-1:0] BLANK_INIT = BLANK_CNT_W'(BLANK_FRAMES);

  logic [STATE_W-1:0]     state_q, state_nx;
  logic [BLANK_CNT_W-1:0] blank_cnt_q, blank_cnt_nx;
  logic [SEL_W-1:0]       sel_nx;
  logic                   switching_nx;
  logic                   vs_prev;
  logic                   fb_c;
  logic [SEL_W-1:0]       auto_idx_c;
  logic                   auto_valid_c;
  logic [SEL_W-1:0]       req_c;
  logic [RGB_W-1:0]       sel_pix_c;
  logic [RGB_W-1:0]       pix_c;
  logic [RGB_W-1:0]       pipe_q [PIPE];

  src_prio_enc #(
    .N (NUM_SRC),
    .W (SEL_W)
  ) u_prio (
    .req   (src_active),
    .idx   (auto_idx_c),
    .valid (auto_valid_c)
  );

  // Requested source; out-of-range manual picks and an idle auto set fall back to the default
  always_comb begin
    req_c = DEF_SEL;
    if (auto_en) begin
      if (auto_valid_c) req_c = auto_idx_c;
    end else if (32'(manual_sel) < NUM_SRC) begin
      req_c = manual_sel;
    end
  end

  // Frame boundary: falling edge of vertical display enable
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) vs_prev <= 1'b0;
    else     vs_prev <= vsync_de;
  end

  assign fb_c = vs_prev & ~vsync_de;

  // State, committed select, blank counter and busy flag
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SHOW;
      cur_sel     <= DEF_SEL;
      blank_cnt_q <= '0;
      switching   <= 1'b0;
    end else begin
      state_q     <= state_nx;
      cur_sel     <= sel_nx;
      blank_cnt_q <= blank_cnt_nx;
      switching   <= switching_nx;
    end
  end

  // Next-state logic; a request seen on the boundary cycle is the one committed
  always_comb begin
    state_nx     = state_q;
    sel_nx       = cur_sel;
    blank_cnt_nx = blank_cnt_q;
    case (state_q)
      ST_SHOW: begin
        if (req_c != cur_sel) state_nx = ST_PEND;
      end
      ST_PEND: begin
        if (req_c == cur_sel) begin
          state_nx = ST_SHOW;
        end else if (fb_c) begin
          sel_nx       = req_c;
          blank_cnt_nx = BLANK_INIT;
          state_nx     = (BLANK_FRAMES == 0) ? ST_SHOW : ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (fb_c) begin
          if (req_c != cur_sel) begin
            // Retarget while black: commit new source and restart the blank period
            sel_nx       = req_c;
            blank_cnt_nx = BLANK_INIT;
          end else if (blank_cnt_q <= BLANK_CNT_W'(1)) begin
            blank_cnt_nx = '0;
            state_nx     = ST_SHOW;
          end else begin
            blank_cnt_nx = blank_cnt_q - BLANK_CNT_W'(1);
          end
        end
      end
      default: state_nx = ST_SHOW;
    endcase
    switching_nx = (state_nx != ST_SHOW);
  end

  // Pixel select; pending switches keep showing the old source
  assign sel_pix_c = src_rgb[32'(cur_sel)*RGB_W +: RGB_W];
  assign pix_c = (hsync_de && vsync_de && (state_q != ST_BLANK)) ? sel_pix_c : RGB_W'(RGB_ZERO);

  // Output delay line
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pix_c;
      for (int i = 1; i < int'(PIPE); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rgb_out = pipe_q[PIPE-1];

endmodule
